// File: rtl/mem_pkg.sv
// Shared decode helpers for the data memory: funct3 encodings, size legality,
// alignment and byte-lane mask generation.
package mem_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned LANES   = 4;
    localparam int unsigned F3_W_BITS = 3;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_NONE = 2'b11
    } acc_size_e;

    typedef struct packed {
        acc_size_e  size;
        logic       legal;
        logic       misaligned;
        logic [3:0] mask;
    } acc_decode_t;

    // Access width implied by funct3[1:0]; the sign bit does not change size.
    function automatic acc_size_e size_of(input logic [2:0] funct3);
        acc_size_e sz;
        case (funct3[1:0])
            2'b00:   sz = SZ_BYTE;
            2'b01:   sz = SZ_HALF;
            2'b10:   sz = SZ_WORD;
            default: sz = SZ_NONE;
        endcase
        return sz;
    endfunction

    function automatic logic size_is_legal(input logic load_nstore, input logic [2:0] funct3);
        logic ok;
        ok = 1'b0;
        if (load_nstore) begin
            case (funct3)
                F3_B, F3_H, F3_W, F3_BU, F3_HU: ok = 1'b1;
                default:                        ok = 1'b0;
            endcase
        end else begin
            case (funct3)
                F3_B, F3_H, F3_W: ok = 1'b1;
                default:          ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic bad;
        case (size_of(funct3))
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = |addr_lo;
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] lane_mask(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic [3:0] m;
        case (size_of(funct3))
            SZ_BYTE: m = 4'b0001 << addr_lo;
            SZ_HALF: m = 4'b0011 << {addr_lo[1], 1'b0};
            SZ_WORD: m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // Store data replicated so every lane carries the bytes it may receive.
    function automatic logic [31:0] store_replicate(input logic [2:0] funct3, input logic [31:0] data);
        logic [31:0] r;
        case (size_of(funct3))
            SZ_BYTE: r = {4{data[7:0]}};
            SZ_HALF: r = {2{data[15:0]}};
            default: r = data;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half of a word and sign- or zero-extends it.
module load_extend
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] value
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = word[8*addr_lo +: 8];
        sel_half = addr_lo[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        value = '0;
        case (funct3)
            F3_B:    value = {{24{sel_byte[7]}}, sel_byte};
            F3_BU:   value = {24'd0, sel_byte};
            F3_H:    value = {{16{sel_half[15]}}, sel_half};
            F3_HU:   value = {16'd0, sel_half};
            F3_W:    value = word;
            default: value = '0;
        endcase
    end

endmodule

// File: rtl/data_memory.sv
// Byte-addressable data memory: synchronous byte-lane stores, combinational
// extended loads, and alignment/size error flags.
module data_memory
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned ADDR_W      = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] Address,
    input  logic [31:0] StoreData,
    output logic [31:0] MemData,
    output logic        Misaligned,
    output logic        IllegalSize
);

    logic [31:0]       mem [DEPTH_WORDS];
    logic [ADDR_W-1:0] widx;
    logic [1:0]        addr_lo;
    logic              access;
    acc_decode_t       dec;
    logic              load_ok;
    logic              wr_en;
    logic [31:0]       wdata;
    logic [31:0]       rd_word;
    logic [31:0]       ext_value;
    logic              unused_addr;

    assign widx        = Address[ADDR_W+1:2];
    assign addr_lo     = Address[1:0];
    assign unused_addr = ^Address[31:ADDR_W+2];

    // Store legality rules win whenever a store is requested.
    always_comb begin
        access         = MemRead | MemWrite;
        dec            = '0;
        dec.size       = size_of(funct3);
        dec.legal      = size_is_legal(~MemWrite, funct3);
        dec.misaligned = is_misaligned(funct3, addr_lo);
        dec.mask       = lane_mask(funct3, addr_lo);
        load_ok        = MemRead & size_is_legal(1'b1, funct3) & ~dec.misaligned;
        wr_en          = MemWrite & dec.legal & ~dec.misaligned;
        wdata          = store_replicate(funct3, StoreData);
    end

    assign Misaligned  = access & dec.misaligned;
    assign IllegalSize = access & ~dec.legal;

    // Reset clears every word and overrides any store in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            for (int unsigned b = 0; b < LANES; b++) begin
                if (dec.mask[b]) begin
                    mem[widx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rd_word = mem[widx];

    load_extend u_load_extend (
        .word    (rd_word),
        .addr_lo (addr_lo),
        .funct3  (funct3),
        .value   (ext_value)
    );

    assign MemData = load_ok ? ext_value : '0;

endmodule

// File: tb/tb_data_memory.sv
// Directed vector table plus randomized traffic against a byte-level memory model.
module tb_data_memory;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  funct3;
    logic [31:0] Address;
    logic [31:0] StoreData;
    logic [31:0] MemData;
    logic        Misaligned;
    logic        IllegalSize;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    data_memory dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .funct3      (funct3),
        .Address     (Address),
        .StoreData   (StoreData),
        .MemData     (MemData),
        .Misaligned  (Misaligned),
        .IllegalSize (IllegalSize)
    );

    typedef struct packed {
        logic        rst;
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] exp_data;
        logic        exp_mis;
        logic        exp_ill;
    } vec_t;

    localparam int NVEC = 24;
    vec_t tbl [NVEC];

    logic [31:0] model [256];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    task automatic drive(input logic r, input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd);
        @(negedge clk);
        rst_n = r; MemRead = rd; MemWrite = wr; funct3 = f3; Address = a; StoreData = sd;
        #2;
    endtask

    function automatic logic load_legal(input logic [2:0] f3);
        return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    endfunction

    function automatic logic store_legal(input logic [2:0] f3);
        return f3 <= 3'd2;
    endfunction

    // Bytes per access: 1 for B/BU, 2 for H/HU, 4 for W.
    function automatic int nbytes(input logic [2:0] f3);
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        if (f3 == 3'd2) return 4;
        return 1;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] w;
        int unsigned off, v;
        w   = model[(a / 4) % 256];
        off = a % 4;
        v   = w >> (8 * off);
        case (f3)
            3'd0: begin v = v % 256;   if (v >= 128)   v = v + 32'hFFFFFF00; end
            3'd4: v = v % 256;
            3'd1: begin v = v % 65536; if (v >= 32768) v = v + 32'hFFFF0000; end
            3'd5: v = v % 65536;
            3'd2: v = w;
            default: v = 0;
        endcase
        return v;
    endfunction

    task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd);
        int unsigned idx, off;
        idx = (a / 4) % 256;
        off = a % 4;
        for (int k = 0; k < nbytes(f3); k++) begin
            model[idx][8*(off+k) +: 8] = sd[8*k +: 8];
        end
    endtask

    initial begin
        logic r, rd, wr, mis, legal, acc;
        logic [2:0]  f3;
        logic [31:0] a, sd, ed;

        rst_n = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; funct3 = 3'd0; Address = '0; StoreData = '0;

        tbl[0]  = '{1'b0, 1'b0, 1'b0, 3'd0, 32'h40,  32'h0,        32'h0,        1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 3'd2, 32'h40,  32'h0,        32'h0,        1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 3'd2, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 3'd2, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 3'd0, 32'h11,  32'h0,        32'hFFFFFFBE, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 3'd4, 32'h11,  32'h0,        32'h000000BE, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 3'd1, 32'h12,  32'h0,        32'hFFFFDEAD, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 3'd5, 32'h12,  32'h0,        32'h0000DEAD, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 3'd0, 32'h13,  32'h12345677, 32'h0,        1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 3'd2, 32'h10,  32'h0,        32'h77ADBEEF, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 3'd1, 32'h10,  32'h0000AAAA, 32'h0,        1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 3'd2, 32'h10,  32'h0,        32'h77ADAAAA, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 3'd2, 32'h12,  32'h55555555, 32'h0,        1'b1, 1'b0};
        tbl[13] = '{1'b1, 1'b1, 1'b0, 3'd2, 32'h10,  32'h0,        32'h77ADAAAA, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 1'b1, 1'b0, 3'd1, 32'h11,  32'h0,        32'h0,        1'b1, 1'b0};
        tbl[15] = '{1'b1, 1'b1, 1'b0, 3'd3, 32'h10,  32'h0,        32'h0,        1'b0, 1'b1};
        tbl[16] = '{1'b1, 1'b0, 1'b1, 3'd2, 32'h400, 32'hCAFEF00D, 32'h0,        1'b0, 1'b0};
        tbl[17] = '{1'b1, 1'b1, 1'b0, 3'd2, 32'h000, 32'h0,        32'hCAFEF00D, 1'b0, 1'b0};
        tbl[18] = '{1'b0, 1'b0, 1'b1, 3'd2, 32'h20,  32'h11111111, 32'h0,        1'b0, 1'b0};
        tbl[19] = '{1'b1, 1'b1, 1'b0, 3'd2, 32'h20,  32'h0,        32'h0,        1'b0, 1'b0};
        tbl[20] = '{1'b1, 1'b1, 1'b1, 3'd2, 32'h30,  32'h2,        32'h0,        1'b0, 1'b0};
        tbl[21] = '{1'b1, 1'b1, 1'b0, 3'd2, 32'h30,  32'h0,        32'h2,        1'b0, 1'b0};
        tbl[22] = '{1'b1, 1'b0, 1'b1, 3'd4, 32'h30,  32'hFF,       32'h0,        1'b0, 1'b1};
        tbl[23] = '{1'b1, 1'b1, 1'b0, 3'd2, 32'h30,  32'h0,        32'h2,        1'b0, 1'b0};

        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i].rst, tbl[i].rd, tbl[i].wr, tbl[i].f3, tbl[i].addr, tbl[i].sdata);
            check($sformatf("vec%0d_data", i), MemData, tbl[i].exp_data);
            check($sformatf("vec%0d_mis", i), 32'(Misaligned), 32'(tbl[i].exp_mis));
            check($sformatf("vec%0d_ill", i), 32'(IllegalSize), 32'(tbl[i].exp_ill));
        end

        // Randomized phase starts from a cleared memory.
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        for (int i = 0; i < 256; i++) model[i] = '0;

        for (int n = 0; n < 3000; n++) begin
            r  = ($urandom_range(0, 63) != 0);
            rd = $urandom_range(0, 1) == 1;
            wr = $urandom_range(0, 1) == 1;
            f3 = (rd && wr) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
            a  = 32'($urandom_range(0, 32'h7FF));
            sd = $urandom;

            acc   = rd | wr;
            legal = wr ? store_legal(f3) : load_legal(f3);
            mis   = (a % nbytes(f3)) != 0;
            ed    = (rd && load_legal(f3) && !mis) ? model_load(f3, a) : 32'h0;

            drive(r, rd, wr, f3, a, sd);
            check($sformatf("rnd%0d_data", n), MemData, ed);
            check($sformatf("rnd%0d_ill", n), 32'(IllegalSize), 32'(acc && !legal));
            if (legal) check($sformatf("rnd%0d_mis", n), 32'(Misaligned), 32'(acc && mis));

            if (!r) begin
                for (int i = 0; i < 256; i++) model[i] = '0;
            end else if (wr && legal && !mis) begin
                model_store(f3, a, sd);
            end
        end

        // Sweep every word back after random traffic.
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 1'b1, 1'b0, 3'd2, 32'(i * 4), 32'h0);
            check($sformatf("sweep%0d", i), MemData, model[i]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Byte-addressable data memory for the single-cycle datapath.
- Sits directly upstream of the MemtoReg write-back select and supplies its MemData input.
- Performs RV32I-style loads (LB/LH/LW/LBU/LHU) with sign or zero extension, and stores (SB/SH/SW) using byte-lane enables.
- Writes are synchronous. Reads are combinational, so the single-cycle timing is preserved.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words; must be a power of 2.
- ADDR_W, 8, word-index width = log2(DEPTH_WORDS).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- MemRead  in  1  load enable.
- MemWrite  in  1  store enable.
- funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- Address  in  32  byte address from the ALU.
- StoreData  in  32  rs2 value; the low bytes are used for SB and SH.
- MemData  out  32  extended load result.
- Misaligned  out  1  access not naturally aligned for its size.
- IllegalSize  out  1  funct3 is not a legal encoding for the requested access.

Behaviour:
- Storage: mem[DEPTH_WORDS] x 32 bits.
  - Word index = Address[ADDR_W+1:2].
  - Upper address bits are ignored, so accesses wrap modulo the memory size.
- Reset: on a rising edge with rst_n=0, every word is cleared to 0 and any store in that cycle is discarded. Reset mid-store leaves the target word at 0.
- Output reset values: MemData, Misaligned and IllegalSize are combinational. With memory cleared they read 0 for any load of a cleared location, and for any cycle with MemRead=0 and MemWrite=0.
- Alignment rules:
  - H/HU/SH require Address[0]=0.
  - W/SW require Address[1:0]=00.
  - Byte accesses are always aligned.
- Misaligned is 1 only when (MemRead|MemWrite)=1 and the access breaks the rules above.
- Legal funct3 encodings:
  - Loads: 000, 001, 010, 100, 101.
  - Stores: 000, 001, 010.
- IllegalSize is 1 when (MemRead|MemWrite)=1 and funct3 is not legal for that access.
- Stores (MemWrite=1, rst_n=1, Misaligned=0, IllegalSize=0):
  - Byte-lane enables: SB 0001<<Address[1:0]; SH 0011<<Address[1:0] (with Address[1] selecting the half); SW 1111.
  - Data is replicated across lanes: SB {4{StoreData[7:0]}}, SH {2{StoreData[15:0]}}, SW StoreData.
  - Only enabled lanes are updated at the clock edge.
- A store that is misaligned or has an illegal size is suppressed; memory is unchanged.
- Loads (MemRead=1):
  - The addressed word is read combinationally.
  - The byte or half is selected by Address[1:0].
  - B/H are sign-extended; BU/HU are zero-extended; W is passed through.
- MemData = 0 when MemRead=0, or when the load is misaligned or has an illegal size.
- Latency: load data is valid in the same cycle; store data is visible to a load from the cycle after the write edge.
- Read-during-write (same cycle, same word): MemData returns the pre-write contents.
- MemRead=1 and MemWrite=1 together:
  - The store is performed.
  - MemData shows the old contents under the load decode.
  - IllegalSize is evaluated against the store rules.

Decomposition:
- Shared package mem_pkg:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - Function size_is_legal(load_nstore, funct3).
  - Function lane_mask(funct3, addr_lo) returning 4 bits.
- Sub-module load_extend (combinational): inputs word, addr_lo[1:0], funct3; output 32-bit extended value. Reused later by any load path.
- The top level holds the array, reset loop, write-lane logic and error flags.

Test Plan:
- Reset: hold rst_n=0 for 1 cycle, then LW at 0x40 -> MemData=0x00000000, Misaligned=0, IllegalSize=0.
- Word store/load: SW 0xDEADBEEF at 0x10; next cycle LW 0x10 -> 0xDEADBEEF.
- Byte loads at 0x11:
  - LB -> 0xFFFFFFBE.
  - LBU -> 0x000000BE.
- Half loads at 0x12:
  - LH -> 0xFFFFDEAD.
  - LHU -> 0x0000DEAD.
- Byte-lane store: SB StoreData=0x12345677 at 0x13 -> LW 0x10 = 0x77ADBEEF. Then SH StoreData=0x0000AAAA at 0x10 -> LW 0x10 = 0x77ADAAAA.
- Misalignment:
  - SW 0x55555555 at 0x12 -> Misaligned=1; LW 0x10 is still 0x77ADAAAA.
  - LH at 0x11 -> Misaligned=1, MemData=0.
- Illegal size: LW with funct3=011 -> IllegalSize=1, MemData=0.
- Wrap-around: SW 0xCAFEF00D at 0x400 (DEPTH 256) -> LW 0x000 = 0xCAFEF00D.
- Reset mid-operation: assert rst_n=0 in the same cycle as SW 0x11111111 at 0x20 -> LW 0x20 = 0.
- Read-during-write: LW and SW 0x2 at 0x30 in the same cycle -> MemData = old value 0; LW 0x30 in the next cycle -> 0x00000002.
